// File: rtl/core_periph_bridge_if.sv
// Bus bundle between the core, the bridge and the FIFO peripheral.
// slave = bridge view; master = environment view (core requester plus peripheral responder).
interface core_periph_bridge_if #(
  parameter int INTERFACE_WIDTH      = 32,
  parameter int INTERFACE_ADDR_WIDTH = 32
);
  logic [INTERFACE_ADDR_WIDTH-1:0] iCoreAddress;
  logic [INTERFACE_WIDTH-1:0]      iCoreWriteData;
  logic [INTERFACE_WIDTH/8-1:0]    iCoreByteEnable;
  logic                            iCoreRead;
  logic                            iCoreWrite;
  logic                            oCoreBusy;
  logic                            oCoreDone;
  logic [INTERFACE_WIDTH-1:0]      oCoreReadData;
  logic                            oCoreError;
  logic [INTERFACE_ADDR_WIDTH-1:0] oWriteAddress;
  logic [INTERFACE_ADDR_WIDTH-1:0] oReadAddress;
  logic [INTERFACE_WIDTH/8-1:0]    oWriteEnable;
  logic [INTERFACE_WIDTH-1:0]      oWriteData;
  logic                            oWriteRequest;
  logic                            oReadRequest;
  logic [INTERFACE_WIDTH-1:0]      iReadData;
  logic                            iReadDataValid;
  logic                            iWriteAccept;

  modport slave (
    input  iCoreAddress, iCoreWriteData, iCoreByteEnable, iCoreRead, iCoreWrite,
    output oCoreBusy, oCoreDone, oCoreReadData, oCoreError,
    output oWriteAddress, oReadAddress, oWriteEnable, oWriteData,
    output oWriteRequest, oReadRequest,
    input  iReadData, iReadDataValid, iWriteAccept
  );

  modport master (
    output iCoreAddress, iCoreWriteData, iCoreByteEnable, iCoreRead, iCoreWrite,
    input  oCoreBusy, oCoreDone, oCoreReadData, oCoreError,
    input  oWriteAddress, oReadAddress, oWriteEnable, oWriteData,
    input  oWriteRequest, oReadRequest,
    output iReadData, iReadDataValid, iWriteAccept
  );
endinterface

// File: rtl/core_periph_bridge.sv
// Core-to-peripheral request bridge: single load/store in flight, timeout-guarded,
// one-cycle completion pulse. All outputs are registered from the next-state decode.
module core_periph_bridge #(
  parameter int                            INTERFACE_WIDTH      = 32,
  parameter int                            INTERFACE_ADDR_WIDTH = 32,
  parameter logic [INTERFACE_ADDR_WIDTH-1:0] ADDR_LOW           = 32'h0000_1000,
  parameter logic [INTERFACE_ADDR_WIDTH-1:0] ADDR_HIGH          = 32'h0000_10FF,
  parameter int                            TIMEOUT_CYCLES       = 255,
  parameter logic [INTERFACE_WIDTH-1:0]    ERROR_DATA           = 32'hFFFF_FFFF
) (
  input logic                 iClk,
  input logic                 iReset,
  core_periph_bridge_if.slave bus
);
  localparam int BE_W = INTERFACE_WIDTH / 8;
  // Counter value seen during the last permitted wait cycle.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_WAIT = 2'd1,
    READ_WAIT  = 2'd2,
    RESPOND    = 2'd3
  } state_t;

  state_t                          state_r, state_next_s;
  logic [INTERFACE_ADDR_WIDTH-1:0] addr_r, addr_next_s;
  logic [INTERFACE_WIDTH-1:0]      wdata_r, wdata_next_s;
  logic [BE_W-1:0]                 be_r, be_next_s;
  logic                            collide_r, collide_next_s;
  logic [7:0]                      count_r, count_next_s;
  logic [INTERFACE_WIDTH-1:0]      rdata_r, rdata_next_s;
  logic                            error_r, error_next_s;
  logic                            busy_r, done_r, wreq_r, rreq_r;
  logic [BE_W-1:0]                 wen_r;
  logic                            timeout_s;

  function automatic logic in_window(input logic [INTERFACE_ADDR_WIDTH-1:0] a);
    return (a >= ADDR_LOW) && (a <= ADDR_HIGH);
  endfunction

  assign timeout_s = (count_r == TMO_LAST);

  // Next-state, capture and completion decode.
  always_comb begin
    state_next_s   = state_r;
    addr_next_s    = addr_r;
    wdata_next_s   = wdata_r;
    be_next_s      = be_r;
    collide_next_s = collide_r;
    count_next_s   = count_r;
    rdata_next_s   = rdata_r;
    error_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if ((bus.iCoreRead || bus.iCoreWrite) && in_window(bus.iCoreAddress)) begin
          addr_next_s    = bus.iCoreAddress;
          wdata_next_s   = bus.iCoreWriteData;
          be_next_s      = bus.iCoreByteEnable;
          collide_next_s = bus.iCoreRead && bus.iCoreWrite;
          count_next_s   = 8'd0;
          state_next_s   = bus.iCoreWrite ? WRITE_WAIT : READ_WAIT;
        end else begin
          state_next_s   = IDLE;
        end
      end
      WRITE_WAIT: begin
        count_next_s = count_r + 8'd1;
        // A handshake in the terminal cycle takes priority over the timeout.
        if (bus.iWriteAccept) begin
          state_next_s = RESPOND;
          error_next_s = collide_r;
        end else if (timeout_s) begin
          state_next_s = RESPOND;
          error_next_s = 1'b1;
        end else begin
          state_next_s = WRITE_WAIT;
        end
      end
      READ_WAIT: begin
        count_next_s = count_r + 8'd1;
        if (bus.iReadDataValid) begin
          state_next_s = RESPOND;
          rdata_next_s = bus.iReadData;
        end else if (timeout_s) begin
          state_next_s = RESPOND;
          rdata_next_s = ERROR_DATA;
          error_next_s = 1'b1;
        end else begin
          state_next_s = READ_WAIT;
        end
      end
      RESPOND: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      state_r   <= IDLE;
      addr_r    <= {INTERFACE_ADDR_WIDTH{1'b0}};
      wdata_r   <= {INTERFACE_WIDTH{1'b0}};
      be_r      <= {BE_W{1'b0}};
      collide_r <= 1'b0;
      count_r   <= 8'd0;
      rdata_r   <= {INTERFACE_WIDTH{1'b0}};
      error_r   <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      wreq_r    <= 1'b0;
      rreq_r    <= 1'b0;
      wen_r     <= {BE_W{1'b0}};
    end else begin
      state_r   <= state_next_s;
      addr_r    <= addr_next_s;
      wdata_r   <= wdata_next_s;
      be_r      <= be_next_s;
      collide_r <= collide_next_s;
      count_r   <= count_next_s;
      rdata_r   <= rdata_next_s;
      error_r   <= error_next_s;
      busy_r    <= (state_next_s != IDLE);
      done_r    <= (state_next_s == RESPOND);
      wreq_r    <= (state_next_s == WRITE_WAIT);
      rreq_r    <= (state_next_s == READ_WAIT);
      wen_r     <= (state_next_s == WRITE_WAIT) ? be_next_s : {BE_W{1'b0}};
    end
  end

  assign bus.oCoreBusy     = busy_r;
  assign bus.oCoreDone     = done_r;
  assign bus.oCoreReadData = rdata_r;
  assign bus.oCoreError    = error_r;
  assign bus.oWriteAddress = addr_r;
  assign bus.oReadAddress  = addr_r;
  assign bus.oWriteEnable  = wen_r;
  assign bus.oWriteData    = wdata_r;
  assign bus.oWriteRequest = wreq_r;
  assign bus.oReadRequest  = rreq_r;
endmodule

// File: tb/tb_core_periph_bridge.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a transaction-level model.
module tb_core_periph_bridge;
  localparam int T = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  core_periph_bridge_if #(.INTERFACE_WIDTH(32), .INTERFACE_ADDR_WIDTH(32)) bus ();

  core_periph_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .iClk   (clk),
    .iReset (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Model: at most one transaction; phase 0 none, 1 waiting for peripheral, 2 completing.
  int          m_phase = 0;
  int          m_age   = 0;
  bit          m_wr, m_col, m_err;
  logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdata = 32'h0;
  logic [3:0]  m_be   = 4'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_err = 1'b0;
      m_addr = 32'h0; m_wdata = 32'h0; m_be = 4'h0; m_rdata = 32'h0;
    end else if (m_phase == 2) begin
      m_phase = 0; m_err = 1'b0;
    end else if (m_phase == 1) begin
      m_age++;
      if (m_wr ? bus.iWriteAccept : bus.iReadDataValid) begin
        m_phase = 2;
        m_err   = m_col;
        if (!m_wr) m_rdata = bus.iReadData;
      end else if (m_age == T) begin
        m_phase = 2;
        m_err   = 1'b1;
        if (!m_wr) m_rdata = 32'hFFFF_FFFF;
      end
    end else if ((bus.iCoreRead || bus.iCoreWrite) &&
                 bus.iCoreAddress >= 32'h1000 && bus.iCoreAddress <= 32'h10FF) begin
      m_phase = 1; m_age = 0;
      m_wr    = bus.iCoreWrite;
      m_col   = bus.iCoreRead && bus.iCoreWrite;
      m_addr  = bus.iCoreAddress; m_wdata = bus.iCoreWriteData; m_be = bus.iCoreByteEnable;
    end
  endtask

  task automatic compare_all();
    logic wq;
    wq = (m_phase == 1) && m_wr;
    chk("busy",  bus.oCoreBusy,     32'(m_phase != 0));
    chk("done",  bus.oCoreDone,     32'(m_phase == 2));
    chk("error", bus.oCoreError,    32'(m_phase == 2 && m_err));
    chk("wreq",  bus.oWriteRequest, 32'(wq));
    chk("rreq",  bus.oReadRequest,  32'((m_phase == 1) && !m_wr));
    chk("wen",   bus.oWriteEnable,  wq ? 32'(m_be) : 32'h0);
    chk("waddr", bus.oWriteAddress, m_addr);
    chk("raddr", bus.oReadAddress,  m_addr);
    chk("wdata", bus.oWriteData,    m_wdata);
    chk("rdata", bus.oCoreReadData, m_rdata);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, check at negedge.
  task automatic cycle(input bit r, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [3:0] be,
                       input logic [31:0] prd, input bit pv, input bit pa);
    rst = r;
    bus.iCoreRead = rd; bus.iCoreWrite = wr; bus.iCoreAddress = a;
    bus.iCoreWriteData = wd; bus.iCoreByteEnable = be;
    bus.iReadData = prd; bus.iReadDataValid = pv; bus.iWriteAccept = pa;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic tick(input bit pv, input bit pa, input logic [31:0] prd);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, prd, pv, pa);
  endtask

  initial begin
    rst = 1'b1;
    bus.iCoreRead = 1'b0; bus.iCoreWrite = 1'b0; bus.iCoreAddress = 32'h0;
    bus.iCoreWriteData = 32'h0; bus.iCoreByteEnable = 4'h0;
    bus.iReadData = 32'h0; bus.iReadDataValid = 1'b0; bus.iWriteAccept = 1'b0;
    @(negedge clk);

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    chk("lit_rst_ctl", {bus.oCoreBusy, bus.oCoreDone, bus.oCoreError, bus.oWriteRequest,
                        bus.oReadRequest, bus.oWriteEnable}, 32'h0);
    chk("lit_rst_addr", bus.oWriteAddress | bus.oReadAddress, 32'h0);
    chk("lit_rst_data", bus.oWriteData | bus.oCoreReadData, 32'h0);

    // Single-cycle read, valid tied high
    cycle(1'b0, 1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, 32'd10, 1'b1, 1'b0);
    chk("lit_rd_req_c1", bus.oReadRequest, 32'h1);
    tick(1'b1, 1'b0, 32'd10);
    chk("lit_rd_done_c2", bus.oCoreDone, 32'h1);
    chk("lit_rd_data_c2", bus.oCoreReadData, 32'd10);
    chk("lit_rd_err_c2", bus.oCoreError, 32'h0);
    tick(1'b1, 1'b0, 32'd10);

    // Delayed write, accept in cycle 4
    cycle(1'b0, 1'b0, 1'b1, 32'h1010, 32'hA5A5_0001, 4'b0011, 32'h0, 1'b1, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      chk("lit_wr_req", bus.oWriteRequest, 32'h1);
      chk("lit_wr_en", bus.oWriteEnable, 32'h3);
      chk("lit_wr_addr", bus.oWriteAddress, 32'h1010);
      chk("lit_wr_data", bus.oWriteData, 32'hA5A5_0001);
      tick(1'b1, (k == 4), 32'h0);
    end
    chk("lit_wr_done_c5", bus.oCoreDone, 32'h1);
    chk("lit_wr_err_c5", bus.oCoreError, 32'h0);
    chk("lit_wr_en_c5", bus.oWriteEnable, 32'h0);
    tick(1'b0, 1'b0, 32'h0);
    chk("lit_wr_en_c6", {bus.oWriteEnable, bus.oCoreBusy}, 32'h0);

    // Window bounds
    cycle(1'b0, 1'b1, 1'b0, 32'h0FFF, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    chk("lit_win_lo_out", {bus.oCoreBusy, bus.oReadRequest}, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h1100, 32'h0, 4'hF, 32'h0, 1'b0, 1'b1);
    chk("lit_win_hi_out", {bus.oCoreBusy, bus.oWriteRequest}, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, 32'h55, 1'b1, 1'b0);
    chk("lit_win_lo_in", {bus.oCoreBusy, bus.oReadRequest}, 32'h3);
    tick(1'b1, 1'b0, 32'h55);
    tick(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 1'b1, 32'h10FF, 32'h77, 4'h1, 32'h0, 1'b0, 1'b1);
    chk("lit_win_hi_in", {bus.oCoreBusy, bus.oWriteRequest}, 32'h3);
    tick(1'b0, 1'b1, 32'h0);
    tick(1'b0, 1'b0, 32'h0);

    // Read timeout, then handshake in the terminal cycle
    cycle(1'b0, 1'b1, 1'b0, 32'h1020, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= T; k++) tick(1'b0, 1'b0, 32'h0);
    chk("lit_tmo_done_c5", bus.oCoreDone, 32'h1);
    chk("lit_tmo_err_c5", bus.oCoreError, 32'h1);
    chk("lit_tmo_data_c5", bus.oCoreReadData, 32'hFFFF_FFFF);
    tick(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b1, 1'b0, 32'h1024, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 1; k <= T; k++) tick((k == T), 1'b0, 32'h1234_5678);
    chk("lit_tmo_hs_done", bus.oCoreDone, 32'h1);
    chk("lit_tmo_hs_err", bus.oCoreError, 32'h0);
    chk("lit_tmo_hs_data", bus.oCoreReadData, 32'h1234_5678);
    tick(1'b0, 1'b0, 32'h0);

    // Collision, then back-to-back at N+2 (request in RESPOND ignored)
    cycle(1'b0, 1'b1, 1'b1, 32'h1000, 32'hDEAD_0000, 4'hF, 32'h0, 1'b1, 1'b0);
    chk("lit_col_strobes", {bus.oWriteRequest, bus.oReadRequest}, 32'h2);
    tick(1'b1, 1'b1, 32'h0);
    chk("lit_col_done_err", {bus.oCoreDone, bus.oCoreError}, 32'h3);
    cycle(1'b0, 1'b0, 1'b1, 32'h1008, 32'h1, 4'h1, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 32'h1004, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    chk("lit_b2b_accept", {bus.oCoreBusy, bus.oReadRequest, bus.oWriteRequest}, 32'h6);

    // Reset mid-READ_WAIT
    tick(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b1, 1'b0);
    chk("lit_midrst", {bus.oCoreDone, bus.oReadRequest, bus.oCoreBusy}, 32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = 32'h0FF0 + 32'($urandom_range(0, 32'h130));
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) == 0) ? 32'h1000 : 32'h10FF;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            a, $urandom, 4'($urandom), $urandom,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/core_periph_bridge.md
# core_periph_bridge

Core-side request bridge upstream of the memory-mapped FIFO peripheral. It captures single load/store requests from the core when the address falls in the peripheral's window, drives the peripheral's read/write request interface, and waits for the peripheral's handshake. It then returns a one-cycle completion pulse, with read data, to the core. A timeout guarantees completion even if the peripheral never responds.

## Interface
Parameters:
- INTERFACE_WIDTH, 32, data width in bits; a multiple of 8.
- INTERFACE_ADDR_WIDTH, 32, address width in bits.
- ADDR_LOW, 32'h0000_1000, first address of the peripheral window, inclusive.
- ADDR_HIGH, 32'h0000_10FF, last address of the peripheral window, inclusive.
- TIMEOUT_CYCLES, 255, wait cycles before abort; 1..255.
- ERROR_DATA, 32'hFFFF_FFFF, read data returned on timeout.

Ports:
- iClk, in, 1, clock; all logic on the rising edge.
- iReset, in, 1, synchronous, active-high reset.
- iCoreAddress, in, INTERFACE_ADDR_WIDTH, core request address.
- iCoreWriteData, in, INTERFACE_WIDTH, core store data.
- iCoreByteEnable, in, INTERFACE_WIDTH/8, store byte lanes.
- iCoreRead, in, 1, load request; sampled only in IDLE.
- iCoreWrite, in, 1, store request; sampled only in IDLE.
- oCoreBusy, out, 1, high while a request is in flight.
- oCoreDone, out, 1, one-cycle completion pulse.
- oCoreReadData, out, INTERFACE_WIDTH, load result; valid when oCoreDone is high after a read.
- oCoreError, out, 1, high with oCoreDone when the access timed out or was a read/write collision.
- oWriteAddress / oReadAddress, out, INTERFACE_ADDR_WIDTH, registered request address.
- oWriteEnable, out, INTERFACE_WIDTH/8, registered byte enables; all zero when no write is in flight.
- oWriteData, out, INTERFACE_WIDTH, registered store data.
- oWriteRequest / oReadRequest, out, 1, peripheral request strobes.
- iReadData, in, INTERFACE_WIDTH, peripheral read data.
- iReadDataValid, in, 1, peripheral read response.
- iWriteAccept, in, 1, peripheral write acceptance.

## Operation
- FSM states: IDLE, WRITE_WAIT, READ_WAIT, RESPOND.
- **IDLE, accepting a request:** a request is accepted when iCoreRead or iCoreWrite is high and ADDR_LOW <= iCoreAddress <= ADDR_HIGH (unsigned compare).
  - On acceptance: register address, data and byte enables; clear the timeout counter.
  - Go to WRITE_WAIT if iCoreWrite is high, otherwise READ_WAIT.
- **IDLE, out-of-window requests:** ignored completely. No busy, no done, no peripheral activity.
- **Collision:** iCoreRead and iCoreWrite both high is a collision. The write is performed, the read is dropped, and the completion carries oCoreError=1.
- **WRITE_WAIT:** oWriteRequest=1, oWriteEnable = captured enables.
  - On iWriteAccept=1 go to RESPOND.
- **READ_WAIT:** oReadRequest=1.
  - On iReadDataValid=1, capture iReadData and go to RESPOND.
  - iReadDataValid is ignored in every other state (the peripheral may hold it permanently high).
- **Timeout:** the counter increments every cycle in a WAIT state. When it reaches TIMEOUT_CYCLES without a handshake, go to RESPOND with error set.
  - On a read timeout, the captured data is ERROR_DATA.
  - A handshake arriving in the same cycle as the timeout wins; no error.
- **RESPOND:** oCoreDone=1 for exactly one cycle, oCoreError valid. Return to IDLE.
- oCoreBusy = (state != IDLE).
- oCoreReadData holds the last captured value until the next read completes; it is not cleared by writes.
- **Reset:**
  - Any state returns to IDLE and the in-flight request is discarded; no done pulse.
  - All outputs are 0: busy, done, error, requests, enables, addresses, write data, read data.

## Timing
- Cycle 0: request accepted in IDLE.
- Cycle 1: oCoreBusy=1 and the peripheral strobe is high. The strobe stays high continuously until the handshake.
- Handshake sampled in cycle N (N >= 1) → RESPOND in cycle N+1, with oCoreDone=1 and data/error valid.
- Cycle N+2: IDLE, and a new request can be accepted in that cycle.
- Minimum latency, request to done, is 2 cycles; back-to-back issue interval is 3 cycles.
- Timeout: with no handshake, oCoreDone rises at cycle TIMEOUT_CYCLES+1.
- Requests presented while busy are not sampled. The core must hold or re-issue a request after oCoreDone.

## Test plan
- **Reset state:** iReset high 2 cycles → every output 0, state IDLE; reset mid-READ_WAIT → no oCoreDone, oReadRequest low on the next cycle.
- **Single-cycle read:** read of 0x1004 with iReadDataValid tied 1 and iReadData=10 → oReadRequest high in cycle 1; oCoreDone=1, oCoreReadData=10, oCoreError=0 in cycle 2.
- **Delayed write:** write of 0x1010, data 0xA5A5_0001, enables 4'b0011, with iWriteAccept asserted in cycle 4 → oWriteRequest high cycles 1–4 with stable address/data/enables; oCoreDone in cycle 5; oWriteEnable=0 afterwards.
- **Window bounds:** requests at 0x0FFF and 0x1100 → no busy, no strobes; requests at 0x1000 and 0x10FF → accepted.
- **Timeout:** TIMEOUT_CYCLES=4, read with iReadDataValid=0 → oCoreDone with oCoreError=1 and oCoreReadData=0xFFFF_FFFF in cycle 5; repeat with valid in the terminal cycle → no error.
- **Collision and back-to-back:** iCoreRead and iCoreWrite both high at 0x1000 → write strobe only, done with error=1; next request accepted exactly in cycle N+2.
